// File: rtl/ula_seq_ctrl_if.sv
// Board-side bundle between ula_seq_ctrl, the switches, the ALU and the display.
// master = board/ALU/bench side, slave = the sequencer.
interface ula_seq_ctrl_if;
  logic       start;
  logic [3:0] sw_a;
  logic [3:0] sw_b;
  logic [2:0] sw_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_res;
  logic       alu_cout;
  logic       alu_ovf;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic       ledr_zero;
  logic       ledr_carry;
  logic       ledr_ovf;
  logic       ledr_neg;
  logic       busy;
  logic       done;

  modport master (
    output start, sw_a, sw_b, sw_op,
    output alu_res, alu_cout, alu_ovf,
    input  alu_a, alu_b, alu_op,
    input  HEX0, HEX1, HEX2,
    input  ledr_zero, ledr_carry, ledr_ovf, ledr_neg,
    input  busy, done
  );

  modport slave (
    input  start, sw_a, sw_b, sw_op,
    input  alu_res, alu_cout, alu_ovf,
    output alu_a, alu_b, alu_op,
    output HEX0, HEX1, HEX2,
    output ledr_zero, ledr_carry, ledr_ovf, ledr_neg,
    output busy, done
  );
endinterface

// File: rtl/ula_seq_ctrl.sv
// ALU operand sequencer: latches operands, converts the result to BCD, drives 7-seg.
// Define ULA_SEQ_CTRL_BLANK_EN to blank leading zero digits on HEX2/HEX1.
module ula_seq_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  ula_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_CONV,
    S_SHOW
  } state_t;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

`ifdef ULA_SEQ_CTRL_BLANK_EN
  localparam logic [6:0] RST_HI = SEG_BLANK;
`else
  localparam logic [6:0] RST_HI = SEG_ZERO;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [11:0] dd_adj(input logic [11:0] b);
    logic [11:0] o;
    o = b;
    for (int i = 0; i < 3; i++) begin
      if (b[i*4 +: 4] >= 4'd5)
        o[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return o;
  endfunction

  state_t      r_state;
  logic        r_start_q;
  logic [2:0]  r_cnt;
  logic [11:0] r_bcd;
  logic [7:0]  r_bin;
  logic [7:0]  r_res;
  logic        r_cout;
  logic        r_ovf;
  logic [3:0]  r_alu_a;
  logic [3:0]  r_alu_b;
  logic [2:0]  r_alu_op;
  logic [6:0]  r_hex0;
  logic [6:0]  r_hex1;
  logic [6:0]  r_hex2;
  logic        r_zero;
  logic        r_carry;
  logic        r_ovf_led;
  logic        r_neg;
  logic        r_done;

  logic        w_req;
  logic [11:0] w_adj;
  logic [19:0] w_dd;
  logic [6:0]  w_hex1;
  logic [6:0]  w_hex2;

  assign w_req = bus.start & ~r_start_q;
  assign w_adj = dd_adj(r_bcd);
  assign w_dd  = {w_adj[10:0], r_bin, 1'b0};

`ifdef ULA_SEQ_CTRL_BLANK_EN
  assign w_hex2 = (r_bcd[11:8] == 4'd0) ? SEG_BLANK
                                        : seg7(r_bcd[11:8]);
  assign w_hex1 = (r_bcd[11:4] == 8'd0) ? SEG_BLANK
                                        : seg7(r_bcd[7:4]);
`else
  assign w_hex2 = seg7(r_bcd[11:8]);
  assign w_hex1 = seg7(r_bcd[7:4]);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_cnt     <= 3'd0;
      r_bcd     <= 12'd0;
      r_bin     <= 8'd0;
      r_res     <= 8'd0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_alu_a   <= 4'd0;
      r_alu_b   <= 4'd0;
      r_alu_op  <= 3'd0;
      r_hex0    <= SEG_ZERO;
      r_hex1    <= RST_HI;
      r_hex2    <= RST_HI;
      r_zero    <= 1'b1;
      r_carry   <= 1'b0;
      r_ovf_led <= 1'b0;
      r_neg     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_start_q <= bus.start;
      r_done    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_alu_a  <= bus.sw_a;
            r_alu_b  <= bus.sw_b;
            r_alu_op <= bus.sw_op;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res   <= bus.alu_res;
          r_bin   <= bus.alu_res;
          r_cout  <= bus.alu_cout;
          r_ovf   <= bus.alu_ovf;
          r_bcd   <= 12'd0;
          r_cnt   <= 3'd0;
          r_state <= S_CONV;
        end
        S_CONV: begin
          {r_bcd, r_bin} <= w_dd;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7)
            r_state <= S_SHOW;
        end
        S_SHOW: begin
          r_hex0    <= seg7(r_bcd[3:0]);
          r_hex1    <= w_hex1;
          r_hex2    <= w_hex2;
          r_zero    <= (r_res == 8'd0);
          r_carry   <= r_cout;
          r_ovf_led <= r_ovf;
          r_neg     <= r_res[7];
          r_done    <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_op     = r_alu_op;
  assign bus.HEX0       = r_hex0;
  assign bus.HEX1       = r_hex1;
  assign bus.HEX2       = r_hex2;
  assign bus.ledr_zero  = r_zero;
  assign bus.ledr_carry = r_carry;
  assign bus.ledr_ovf   = r_ovf_led;
  assign bus.ledr_neg   = r_neg;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Directed + random bench for ula_seq_ctrl against a decimal-digit reference model.
// Honours ULA_SEQ_CTRL_BLANK_EN in its expected display values.
module tb_ula_seq_ctrl;

  logic clk;
  logic rst_n;
  int   vec;
  int   bad;

  ula_seq_ctrl_if bus();

  ula_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] SEG [10];
  logic [6:0] e_hex0, e_hex1, e_hex2;
  logic       e_zero, e_carry, e_ovf, e_neg;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_reset();
    e_hex0 = 7'b1000000;
`ifdef ULA_SEQ_CTRL_BLANK_EN
    e_hex1 = 7'b1111111;
    e_hex2 = 7'b1111111;
`else
    e_hex1 = 7'b1000000;
    e_hex2 = 7'b1000000;
`endif
    e_zero  = 1'b1;
    e_carry = 1'b0;
    e_ovf   = 1'b0;
    e_neg   = 1'b0;
  endtask

  task automatic exp_result(input int r, input logic c, input logic v);
    int u, t, h;
    u = r % 10;
    t = (r / 10) % 10;
    h = r / 100;
    e_hex0 = SEG[u];
    e_hex1 = SEG[t];
    e_hex2 = SEG[h];
`ifdef ULA_SEQ_CTRL_BLANK_EN
    if (h == 0) e_hex2 = 7'b1111111;
    if (h == 0 && t == 0) e_hex1 = 7'b1111111;
`endif
    e_zero  = (r == 0);
    e_carry = c;
    e_ovf   = v;
    e_neg   = (r >= 128);
  endtask

  task automatic chk_disp(input string tag);
    chk({tag, "_hex0"}, bus.HEX0, e_hex0);
    chk({tag, "_hex1"}, bus.HEX1, e_hex1);
    chk({tag, "_hex2"}, bus.HEX2, e_hex2);
    chk({tag, "_zero"}, bus.ledr_zero, e_zero);
    chk({tag, "_carry"}, bus.ledr_carry, e_carry);
    chk({tag, "_ovf"}, bus.ledr_ovf, e_ovf);
    chk({tag, "_neg"}, bus.ledr_neg, e_neg);
  endtask

  // hold: negedges start stays high; retrig: edge index of a 2nd 0->1
  task automatic run_op(input string tag,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] o, input logic [7:0] r,
                        input logic c, input logic v,
                        input int hold, input int retrig);
    int dn;
    dn = 0;
    @(negedge clk);
    bus.sw_a     = a;
    bus.sw_b     = b;
    bus.sw_op    = o;
    bus.alu_res  = r;
    bus.alu_cout = c;
    bus.alu_ovf  = v;
    bus.start    = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      bus.start = (i < hold) || (retrig != 0 && i >= retrig);
      if (retrig != 0 && i == retrig) bus.sw_a = ~a;
      if (bus.done) dn++;
      if (i == 1) begin
        chk({tag, "_alu_a"}, bus.alu_a, a);
        chk({tag, "_alu_b"}, bus.alu_b, b);
        chk({tag, "_alu_op"}, bus.alu_op, o);
        chk({tag, "_busy"}, bus.busy, 1);
      end
      if (i == 10) begin
        chk({tag, "_hold_hex0"}, bus.HEX0, e_hex0);
        chk({tag, "_busy_show"}, bus.busy, 1);
      end
      if (i == 11) begin
        exp_result(int'(r), c, v);
        chk_disp(tag);
        chk({tag, "_done"}, bus.done, 1);
      end
    end
    for (int j = 12; j <= hold + 2; j++) begin
      @(negedge clk);
      bus.start = (j < hold);
      if (bus.done) dn++;
    end
    @(negedge clk);
    if (bus.done) dn++;
    chk({tag, "_idle"}, bus.busy, 0);
    chk({tag, "_ndone"}, dn, 1);
    chk({tag, "_stable_a"}, bus.alu_a, a);
    chk_disp({tag, "_hold"});
    bus.start = 1'b0;
  endtask

  initial begin
    int dn;
    SEG = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    vec = 0;
    bad = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.sw_a     = 4'd0;
    bus.sw_b     = 4'd0;
    bus.sw_op    = 3'd0;
    bus.alu_res  = 8'd0;
    bus.alu_cout = 1'b0;
    bus.alu_ovf  = 1'b0;
    exp_reset();
    repeat (3) @(negedge clk);
    chk_disp("rst");
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    rst_n = 1'b1;

    run_op("add15", 4'd9, 4'd6, 3'd0, 8'd15, 1'b0, 1'b0, 1, 0);
    run_op("zero", 4'd8, 4'd8, 3'd0, 8'd0, 1'b1, 1'b0, 1, 0);
    run_op("max", 4'd15, 4'd15, 3'd2, 8'd255, 1'b0, 1'b1, 1, 0);
    run_op("retrig", 4'd3, 4'd4, 3'd1, 8'd107, 1'b0, 1'b0, 1, 4);
    run_op("showedge", 4'd5, 4'd2, 3'd3, 8'd200, 1'b1, 1'b1, 1, 10);
    run_op("held", 4'd7, 4'd1, 3'd4, 8'd99, 1'b0, 1'b0, 30, 0);

    // reset in the middle of an operation
    @(negedge clk);
    bus.sw_a    = 4'd6;
    bus.alu_res = 8'd42;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_reset();
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_alu_a", bus.alu_a, 0);
    chk_disp("abort");
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("abort_nodone", dn, 0);
    run_op("after_rst", 4'd2, 4'd2, 3'd0, 8'd4, 1'b0, 1'b0, 1, 0);

    for (int k = 0; k < 16; k++) begin
      run_op("rnd", 4'($urandom), 4'($urandom), 3'($urandom),
             8'($urandom_range(0, 255)), 1'($urandom), 1'($urandom),
             int'($urandom_range(1, 3)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
